// File: rtl/axil_master.sv
// AXI4-Lite initiator: one command in, one AXI transaction out, one response back.
// Latency: accept -> rsp_valid is 3 cycles with a zero-wait slave; rsp -> next cmd_ready is 1 cycle.
// Backpressure: cmd_ready low while busy; rsp held until rsp_ready; AXI valids held until handshake.
//
// Ports:
//   s_axi_aclk / s_axi_aresetn : clock, async active-low reset
//   cmd_*                      : command in (valid/ready), write flag, address, write data
//   rsp_*                      : response out (valid/ready), read data, resp code, write echo
//   busy, timeout_err          : status (not idle, sticky channel timeout)
//   m_axi_*                    : AXI4-Lite master channels AW, W, B, AR, R
module axil_master #(
  parameter int C_DATA_W  = 32,
  parameter int C_ADDR_W  = 32,
  parameter int C_TIMEOUT = 1024
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [C_ADDR_W-1:0] cmd_addr,
  input  logic [C_DATA_W-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [C_DATA_W-1:0] rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_write,
  output logic                busy,
  output logic                timeout_err,
  output logic [C_ADDR_W-1:0] m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [C_DATA_W-1:0] m_axi_wdata,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [C_ADDR_W-1:0] m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [C_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int            CW     = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(C_TIMEOUT);
  localparam bit            TO_EN  = (C_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t r_state, w_state_nxt;

  // every output is a register; the *_nxt wires are their next values
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [C_DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]          r_rsp_resp,  w_rsp_resp_nxt;
  logic                r_rsp_write, w_rsp_write_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_to_err,    w_to_err_nxt;
  logic [CW-1:0]       r_cnt,       w_cnt_nxt;
  logic [C_ADDR_W-1:0] r_addr,      w_addr_nxt;
  logic [C_DATA_W-1:0] r_wdata,     w_wdata_nxt;
  logic                r_awvalid,   w_awvalid_nxt;
  logic                r_wvalid,    w_wvalid_nxt;
  logic                r_bready,    w_bready_nxt;
  logic                r_arvalid,   w_arvalid_nxt;
  logic                r_rready,    w_rready_nxt;

  logic w_accept;
  logic w_wait;
  logic w_hs;

  assign w_accept = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;

  // states in which some AXI valid/ready is outstanding and the timeout runs
  assign w_wait = (r_state == S_WR_ADDR_DATA) || (r_state == S_WR_RESP) ||
                  (r_state == S_RD_ADDR)      || (r_state == S_RD_DATA);

  // any channel handshake this cycle restarts the timeout count
  always_comb begin
    w_hs = 1'b0;
    case (r_state)
      S_WR_ADDR_DATA: w_hs = (r_awvalid && m_axi_awready) || (r_wvalid && m_axi_wready);
      S_WR_RESP:      w_hs = r_bready && m_axi_bvalid;
      S_RD_ADDR:      w_hs = r_arvalid && m_axi_arready;
      S_RD_DATA:      w_hs = r_rready && m_axi_rvalid;
      default:        w_hs = 1'b0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_rsp_write_nxt = r_rsp_write;
    w_busy_nxt      = r_busy;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;

    case (r_state)
      S_IDLE: begin
        // cmd_ready comes up one cycle after reset release
        w_cmd_ready_nxt = 1'b1;
        if (w_accept) begin
          w_cmd_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          w_addr_nxt      = cmd_addr;
          w_wdata_nxt     = cmd_wdata;
          w_rsp_write_nxt = cmd_write;
          if (cmd_write) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WR_ADDR_DATA;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_RD_ADDR;
          end
        end
      end

      S_WR_ADDR_DATA: begin
        // AW and W retire independently; a low valid means that channel is done
        w_awvalid_nxt = r_awvalid && !m_axi_awready;
        w_wvalid_nxt  = r_wvalid  && !m_axi_wready;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          w_bready_nxt    = 1'b0;
          w_rsp_resp_nxt  = m_axi_bresp;
          w_rsp_rdata_nxt = '0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RSP;
        end
      end

      S_RD_ADDR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          w_rready_nxt    = 1'b0;
          w_rsp_resp_nxt  = m_axi_rresp;
          w_rsp_rdata_nxt = m_axi_rdata;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Timeout: saturating count of cycles without a handshake; the flag is
  // raised on the edge the count reaches the limit and the FSM keeps waiting.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_to_err_nxt = r_to_err;
    if (w_accept) begin
      w_cnt_nxt    = '0;
      w_to_err_nxt = 1'b0;
    end else if (w_wait) begin
      if (w_hs) begin
        w_cnt_nxt = '0;
      end else if (TO_EN && (r_cnt != TO_MAX)) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
      if (TO_EN && !w_hs && (w_cnt_nxt == TO_MAX)) begin
        w_to_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_rsp_write <= 1'b0;
      r_busy      <= 1'b0;
      r_to_err    <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_rsp_write <= w_rsp_write_nxt;
      r_busy      <= w_busy_nxt;
      r_to_err    <= w_to_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_write     = r_rsp_write;
  assign busy          = r_busy;
  assign timeout_err   = r_to_err;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: directed commands against a configurable AXI-Lite slave.
// Expected responses come from a memory model and the slave's configured response codes.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_write;
  logic        busy;
  logic        timeout_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  axil_master #(.C_DATA_W(32), .C_ADDR_W(32), .C_TIMEOUT(16)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .busy(busy), .timeout_err(timeout_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- slave configuration and model ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit          ovr_en = 0;
  logic [31:0] ovr_data = '0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        wr;
  } exp_t;
  exp_t exp_q[$];

  // slave: ready/valid after a configured number of waiting cycles
  initial begin
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [31:0] s_addr = '0, s_data = '0, s_rdata = '0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end else begin
        if (awvalid && awready) begin s_addr = awaddr; aw_got = 1; end
        if (wvalid && wready) begin s_data = wdata; w_got = 1; end
        if (aw_got && w_got) begin
          slave_mem[s_addr] = s_data;
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
        end
        if (bvalid && bready) b_pend = 0;
        if (arvalid && arready) begin
          r_pend = 1; r_wait = 0;
          s_rdata = ovr_en ? ovr_data : (slave_mem.exists(araddr) ? slave_mem[araddr] : 32'h0);
        end
        if (rvalid && rready) r_pend = 0;
      end
      @(posedge clk); #1;
      awready = awvalid && (aw_wait >= aw_dly);
      aw_wait = awvalid ? aw_wait + 1 : 0;
      wready  = wvalid && (w_wait >= w_dly);
      w_wait  = wvalid ? w_wait + 1 : 0;
      arready = arvalid && (ar_wait >= ar_dly);
      ar_wait = arvalid ? ar_wait + 1 : 0;
      bvalid  = b_pend && (b_wait >= b_dly);
      bresp   = bvalid ? bresp_cfg : 2'b00;
      if (b_pend) b_wait++;
      rvalid  = r_pend && (r_wait >= r_dly);
      rdata   = rvalid ? s_rdata : 32'h0;
      rresp   = rvalid ? rresp_cfg : 2'b00;
      if (r_pend) r_wait++;
    end
  end

  // ---------------- per-cycle compare process ----------------
  initial begin
    logic        p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
    logic        p_b = 0, p_bv = 0, p_r = 0, p_rv = 0, p_rsp = 0, p_rspr = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0, p_rdata = '0;
    logic [1:0]  p_resp = '0;
    logic        p_write = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        chk("reset_outputs", {cmd_ready, rsp_valid, busy, timeout_err, awvalid, wvalid,
                              bready, arvalid, rready}, 64'h0);
        p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0; p_rsp = 0;
      end else begin
        if (p_aw && !p_awr) chk("awvalid_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_w && !p_wr)   chk("wvalid_hold", {wvalid, wdata}, {1'b1, p_wdata});
        if (p_ar && !p_arr) chk("arvalid_hold", {arvalid, araddr}, {1'b1, p_araddr});
        if (p_b && !p_bv)   chk("bready_hold", bready, 1'b1);
        if (p_r && !p_rv)   chk("rready_hold", rready, 1'b1);
        if (p_rsp && !p_rspr)
          chk("rsp_hold", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
              {1'b1, p_write, p_resp, p_rdata});
        if (cmd_ready && busy) chk("ready_vs_busy", 1'b1, 1'b0);
        if (rsp_valid) begin
          chk("rsp_no_axi", {awvalid, wvalid, bready, arvalid, rready}, 64'h0);
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 1'b0);
          end else begin
            chk("rsp_fields", {rsp_write, rsp_resp, rsp_rdata},
                {exp_q[0].wr, exp_q[0].resp, exp_q[0].rdata});
            if (rsp_ready) void'(exp_q.pop_front());
          end
        end
        p_aw = awvalid; p_awr = awready; p_awaddr = awaddr;
        p_w = wvalid; p_wr = wready; p_wdata = wdata;
        p_ar = arvalid; p_arr = arready; p_araddr = araddr;
        p_b = bready; p_bv = bvalid; p_r = rready; p_rv = rvalid;
        p_rsp = rsp_valid; p_rspr = rsp_ready;
        p_rdata = rsp_rdata; p_resp = rsp_resp; p_write = rsp_write;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int tr_aw, tr_w, tr_b, tr_bfirst, tr_wlast, tr_tofirst, tr_rsp;
  logic [31:0] tr_rdata;
  logic [1:0]  tr_resp;
  logic        tr_write;

  // called just after a rising edge; returns just after the accept edge
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit done = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        done = 1;
        e.wr = w;
        if (w) begin
          e.rdata = 32'h0; e.resp = bresp_cfg; model_mem[a] = d;
        end else begin
          e.rdata = ovr_en ? ovr_data : (model_mem.exists(a) ? model_mem[a] : 32'h0);
          e.resp  = rresp_cfg;
        end
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("cmd_accept_timeout", 1'b0, 1'b1);
  endtask

  // samples k = 1.. cycles after accept until rsp_valid is seen
  task automatic trace(input int max);
    tr_aw = 0; tr_w = 0; tr_b = 0; tr_bfirst = -1; tr_wlast = -1; tr_tofirst = -1; tr_rsp = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (awvalid) tr_aw++;
      if (wvalid) begin tr_w++; tr_wlast = k; end
      if (bready) begin tr_b++; if (tr_bfirst < 0) tr_bfirst = k; end
      if (timeout_err && tr_tofirst < 0) tr_tofirst = k;
      if (rsp_valid) begin
        tr_rsp = k; tr_rdata = rsp_rdata; tr_resp = rsp_resp; tr_write = rsp_write;
        break;
      end
    end
    if (tr_rsp < 0) chk("rsp_wait_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_timeout_err", timeout_err, 1'b0);
    @(posedge clk); #1;

    // zero-wait write then read back
    send_cmd(1'b1, 32'h0000_000C, 32'hDEAD_BEEF);
    trace(20);
    chk("w0_awvalid_cycles", tr_aw, 1);
    chk("w0_wvalid_cycles", tr_w, 1);
    chk("w0_bready_cycles", tr_b, 1);
    chk("w0_latency", tr_rsp, 3);
    chk("w0_resp", tr_resp, 2'b00);
    chk("w0_write", tr_write, 1'b1);
    chk("w0_rdata", tr_rdata, 32'h0);
    send_cmd(1'b0, 32'h0000_000C, 32'h0);
    trace(20);
    chk("r0_latency", tr_rsp, 3);
    chk("r0_rdata", tr_rdata, 32'hDEAD_BEEF);
    chk("r0_resp", tr_resp, 2'b00);
    chk("r0_write", tr_write, 1'b0);

    // AW ready after 2 waiting cycles, W after 5
    aw_dly = 2; w_dly = 5;
    send_cmd(1'b1, 32'h0000_0044, 32'hA5A5_0F0F);
    trace(40);
    chk("w1_awvalid_cycles", tr_aw, 3);
    chk("w1_wvalid_cycles", tr_w, 6);
    chk("w1_wlast", tr_wlast, 6);
    chk("w1_bready_first", tr_bfirst, 7);
    chk("w1_latency", tr_rsp, 8);
    aw_dly = 0; w_dly = 0;

    // read with SLVERR and forced data
    rresp_cfg = 2'b10; ovr_en = 1; ovr_data = 32'h1234_5678;
    send_cmd(1'b0, 32'h0000_0010, 32'h0);
    trace(20);
    chk("r1_resp", tr_resp, 2'b10);
    chk("r1_rdata", tr_rdata, 32'h1234_5678);
    rresp_cfg = 2'b00; ovr_en = 0;

    // response backpressure with a command waiting
    rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h0000_0020, 32'h0BAD_F00D);
    trace(20);
    cmd_write = 1'b0; cmd_addr = 32'h0000_000C; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_axi_idle", {awvalid, wvalid, arvalid}, 3'b000);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rsp_dropped", rsp_valid, 1'b0);
    chk("bp_cmd_ready_back", cmd_ready, 1'b1);
    begin
      exp_t e;
      e.wr = 1'b0; e.resp = 2'b00; e.rdata = model_mem[32'h0000_000C];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_arvalid", arvalid, 1'b1);
    @(posedge clk); #1;
    trace(20);
    chk("bp_next_rdata", tr_rdata, 32'hDEAD_BEEF);

    // B withheld long enough to trip the 16-cycle timeout
    b_dly = 40; bresp_cfg = 2'b01;
    send_cmd(1'b1, 32'h0000_0030, 32'hCAFE_0001);
    trace(100);
    chk("to_after_16", tr_tofirst - tr_bfirst, 16);
    chk("to_bready_cycles", tr_b, 41);
    chk("to_resp", tr_resp, 2'b01);
    @(negedge clk);
    chk("to_sticky", timeout_err, 1'b1);
    @(posedge clk); #1;
    b_dly = 0; bresp_cfg = 2'b00;
    send_cmd(1'b0, 32'h0000_0030, 32'h0);
    @(negedge clk);
    chk("to_cleared", timeout_err, 1'b0);
    @(posedge clk); #1;
    trace(20);
    chk("to_readback", tr_rdata, 32'hCAFE_0001);

    // reset while arvalid is waiting
    ar_dly = 20;
    send_cmd(1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    chk("rst_arvalid_before", arvalid, 1'b1);
    @(posedge clk); #3;
    aresetn = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_arvalid", arvalid, 1'b0);
    chk("rst_mid_rready", rready, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    ar_dly = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    send_cmd(1'b0, 32'h0000_000C, 32'h0);
    trace(20);
    chk("post_rst_rdata", tr_rdata, 32'hDEAD_BEEF);
    chk("post_rst_latency", tr_rsp, 3);

    repeat (3) @(posedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- Synthesizable AXI4-Lite initiator: the master-side counterpart of axil_reg_wrapper.
- Converts single-beat commands from an internal controller (gait sequencer, servo scheduler) into AXI4-Lite read/write transactions.
- Returns one response per command.
- One outstanding transaction at a time; no pipelining across commands.

Parameters:
- C_DATA_W, 32, AXI data width and cmd/rsp data width.
- C_ADDR_W, 32, AXI address width.
- C_TIMEOUT, 1024, cycles waited on any single AXI channel before flagging timeout_err; 0 disables the timeout.

Ports:
- s_axi_aclk  in  1  clock; all logic on rising edge.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  C_ADDR_W  target byte address.
- cmd_wdata  in  C_DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  out  C_DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP of the transaction.
- rsp_write  out  1  echo of cmd_write.
- busy  out  1  high whenever not in IDLE.
- timeout_err  out  1  sticky channel-timeout flag.
- m_axi_awaddr  out  C_ADDR_W  AW address.
- m_axi_awvalid  out  1  AW valid.
- m_axi_awready  in  1  AW ready.
- m_axi_wdata  out  C_DATA_W  W data.
- m_axi_wvalid  out  1  W valid.
- m_axi_wready  in  1  W ready.
- m_axi_bresp  in  2  B response.
- m_axi_bvalid  in  1  B valid.
- m_axi_bready  out  1  B ready.
- m_axi_araddr  out  C_ADDR_W  AR address.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rdata  in  C_DATA_W  R data.
- m_axi_rresp  in  2  R response.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.

Behaviour:
- Reset (async, s_axi_aresetn=0): FSM=IDLE, all outputs 0 except cmd_ready=1 after reset release; timeout counter=0. Asserting reset mid-transaction drops every valid/ready immediately and discards the pending command and response.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept at edge N: latch addr/wdata/write; cmd_ready=0 from N+1; clear timeout counter and timeout_err.
  - write: awvalid=wvalid=1 from N+1 -> WR_ADDR_DATA.
  - read: arvalid=1 from N+1 -> RD_ADDR.
- WR_ADDR_DATA: awvalid drops the cycle after the AW handshake; wvalid drops the cycle after the W handshake; handshakes may occur in either order or together. Once both are done: bready=1 -> WR_RESP. awaddr/wdata stay stable while the corresponding valid is high.
- WR_RESP: on bvalid&&bready, capture bresp, rsp_rdata=0, bready=0 -> RSP.
- RD_ADDR: on arready, arvalid=0, rready=1 -> RD_DATA.
- RD_DATA: on rvalid&&rready, capture rdata/rresp, rready=0 -> RSP.
- RSP: rsp_valid=1; rsp_* stable until rsp_ready. On handshake, rsp_valid=0 and cmd_ready=1 next cycle (IDLE).
- Minimum command-to-rsp_valid latency, slave ready and responding immediately: write 3 cycles, read 3 cycles. Minimum rsp-to-next-cmd_ready gap: 1 cycle.
- Valids, once asserted, never drop before their handshake (AXI rule), including on timeout.
- Timeout:
  - The counter increments each cycle while a valid or ready is waiting in WR_ADDR_DATA/WR_RESP/RD_ADDR/RD_DATA, and resets on each channel handshake.
  - When count reaches C_TIMEOUT, timeout_err=1 (sticky) and the FSM keeps waiting.
  - timeout_err clears only on reset or the next command accept. The counter saturates.
- busy=1 in every state except IDLE.

Test Plan:
- Write 0x0000000C/0xDEADBEEF, zero-wait slave -> awvalid and wvalid high exactly 1 cycle, bready 1 cycle, rsp_valid 3 cycles after accept, rsp_resp=00, rsp_write=1; then read 0x0C -> rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Slave asserts awready 2 cycles and wready 5 cycles after valid -> awvalid drops after cycle 2, wvalid stays high until cycle 5, bready rises only after both; awaddr/wdata stable throughout.
- Read 0x10 with rresp=10 and rdata=0x12345678 -> rsp_resp=10, rsp_rdata=0x12345678.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp_valid and data held, cmd_ready=0, no AXI valids; after rsp_ready, the next command is accepted the following cycle.
- C_TIMEOUT=16, slave withholds bvalid 40 cycles -> timeout_err=1 after 16 waiting cycles, bready held; response later delivered; next accept clears timeout_err.
- Reset pulsed while arvalid high -> arvalid/rready/busy=0 immediately; after release cmd_ready=1, no stray rsp_valid.
